fft_inpl_mac_ctrl: RTL and testbench
====================================

Name: fft_inpl_mac_ctrl

Overview:
Initiator-side controller for the in-place FFT hard-MAC wrapper.
- Accepts operand pairs plus an optional carry term on a valid/ready stream.
- Drives the MAC enables, multiplicands, carryin and sync reset.
- Tracks the MAC's register-dependent latency with a valid pipeline.
- Captures the wide product, applies convergent rounding and saturation, and returns narrow results on a valid/ready stream with backpressure.

Parameters:
WIDTH_A, 18, multiplicand A width (max 18)
WIDTH_B, 18, multiplicand B width (max 18)
BYPASS_REG_A, 0, 1 = MAC A/B input registers bypassed; must equal the wrapper setting; BYPASS_REG_B is tied to the same value
BYPASS_REG_P, 0, 1 = MAC P register bypassed
P_WIDTH, 41, MAC product/accumulator width
OUT_WIDTH, 18, signed result width
SHIFT, 17, LSBs dropped by rounding (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  controller can accept a beat
in_a  in  WIDTH_A  signed multiplicand A
in_b  in  WIDTH_B  signed multiplicand B
in_c  in  P_WIDTH  signed addend, added to the product
mac_rstn  out  1  MAC sync reset, active low
mac_en_a  out  1  MAC A register enable
mac_en_b  out  1  MAC B register enable
mac_en_p  out  1  MAC P register enable
mac_mcand_a  out  WIDTH_A  to MAC
mac_mcand_b  out  WIDTH_B  to MAC
mac_carryin  out  P_WIDTH  to MAC (cdsel=0, shftsel=0, sub=0 at the wrapper)
mac_pout  in  P_WIDTH  MAC product
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_data  out  OUT_WIDTH  rounded, saturated result
out_ovfl  out  1  saturation occurred on this result

Behaviour:
- Reset:
  - mac_rstn = ~rst, combinational.
  - On rst: out_valid=0, out_data=0, out_ovfl=0, valid pipeline cleared, carry delay register cleared.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight beats; no partial output.
- Latency:
  - L_MAC = (1-BYPASS_REG_A) + (1-BYPASS_REG_P), range 0..2.
  - An accepted beat appears on out_valid exactly L_MAC+1 cycles later when not stalled (default 3).
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - mac_en_a = mac_en_b = mac_en_p = ~stall.
  - valid pipeline and carry delay advance only when ~stall.
- Operands:
  - mac_mcand_a = in_a and mac_mcand_b = in_b, combinational pass-through.
  - Beats with in_valid=0 still advance the MAC as bubbles (valid bit 0).
- Carry alignment:
  - When BYPASS_REG_A=0, in_c passes through one enabled register so it meets its product at the adder.
  - When BYPASS_REG_A=1, in_c drives mac_carryin directly.
- Valid pipeline: a shift register of depth L_MAC; its bit enters in_valid&in_ready.
- Output register, loaded when ~stall:
  - out_valid <= pipeline tail (or the accepted bit if L_MAC=0).
  - out_data/out_ovfl are loaded only when the tail bit is 1; otherwise they hold.
- Rounding:
  - q = mac_pout >>> SHIFT (arithmetic); f = mac_pout[SHIFT-1:0]; h = 2^(SHIFT-1).
  - Increment q if f>h, or if f==h and q[0]==1 (round half to even).
  - Compute in OUT_WIDTH+1+ bits so that incrementing cannot wrap.
- Saturation:
  - If rounded > 2^(OUT_WIDTH-1)-1: output max, out_ovfl=1.
  - If rounded < -2^(OUT_WIDTH-1): output min, out_ovfl=1.
  - Otherwise out_ovfl=0.
- Simultaneous accept and output:
  - With out_ready=1 and out_valid=1, a new result loads in the same cycle the old one transfers.
  - Sustains full throughput of 1 beat/cycle.
- During stall, out_data, out_ovfl and out_valid hold stable.

Optional Feature:
FFT_INPL_MAC_CTRL_STATS_EN
- Defined:
  - Adds ports ovfl_clr (in, 1) and ovfl_cnt (out, 16).
  - ovfl_cnt increments on each transferred beat (out_valid&out_ready) with out_ovfl=1.
  - ovfl_cnt saturates at 16'hFFFF.
  - Cleared by rst or ovfl_clr; clear wins over a simultaneous increment.
- Undefined: the ports are still present; ovfl_cnt is constant 0 and ovfl_clr is ignored; no counter logic.

Test Plan:
1. Defaults, out_ready=1, single beat a=1000, b=1000, c=0 -> out_valid exactly 3 cycles later, out_data=8, out_ovfl=0.
2. Tie-to-even: a=256,b=256 (0.5) -> out_data=0; a=256,b=768 (1.5) -> out_data=2; a=-256,b=256 (-0.5) -> out_data=0.
3. Saturation: a=-131072, b=-131072 -> out_data=131071, out_ovfl=1; with STATS_EN, ovfl_cnt increments to 1.
4. Carry alignment: back-to-back beats (1,1,c=3*2^17) then (2,2,c=0) -> outputs 3 then 0.
5. Backpressure: stream 8 beats a=k,b=2^17 (k=1..8), out_ready low for cycles 4-7 -> outputs 1..8 in order; no loss or duplication; in_ready=0 and mac_en_*=0 while stalled.
6. Reset mid-operation: rst pulsed 1 cycle with 2 beats in flight -> no out_valid for those beats; next beat a=3,b=2^17 -> out_data=3 after 3 cycles.
   - Repeat with BYPASS_REG_A=1, BYPASS_REG_P=1 -> latency of 1 cycle.

Source files
------------

// File: rtl/fft_inpl_mac_ctrl.sv
// Initiator-side controller for the in-place FFT hard MAC: operand stream in, rounded and
// saturated results out. Optional overflow counter enabled by FFT_INPL_MAC_CTRL_STATS_EN.
module fft_inpl_mac_ctrl #(
  parameter int WIDTH_A      = 18,
  parameter int WIDTH_B      = 18,
  parameter int BYPASS_REG_A = 0,
  parameter int BYPASS_REG_P = 0,
  parameter int P_WIDTH      = 41,
  parameter int OUT_WIDTH    = 18,
  parameter int SHIFT        = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_A-1:0]   in_a,
  input  logic [WIDTH_B-1:0]   in_b,
  input  logic [P_WIDTH-1:0]   in_c,
  output logic                 mac_rstn,
  output logic                 mac_en_a,
  output logic                 mac_en_b,
  output logic                 mac_en_p,
  output logic [WIDTH_A-1:0]   mac_mcand_a,
  output logic [WIDTH_B-1:0]   mac_mcand_b,
  output logic [P_WIDTH-1:0]   mac_carryin,
  input  logic [P_WIDTH-1:0]   mac_pout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_ovfl,
  input  logic                 ovfl_clr,
  output logic [15:0]          ovfl_cnt
);

  localparam int L_MAC = (1 - BYPASS_REG_A) + (1 - BYPASS_REG_P);
  // Wide enough that the rounding increment never wraps before the saturation compare.
  localparam int RW    = ((P_WIDTH > OUT_WIDTH) ? P_WIDTH : OUT_WIDTH) + 2;
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = ~MAXV;
  localparam logic [SHIFT-1:0]     HALF = SHIFT'(1) << (SHIFT - 1);

  logic                 w_stall;
  logic                 w_acc;
  logic                 w_tail;
  logic signed [RW-1:0] w_pext;
  logic signed [RW-1:0] w_q;
  logic signed [RW-1:0] w_r;
  logic [SHIFT-1:0]     w_frac;
  logic                 w_inc;
  logic [OUT_WIDTH-1:0] w_sat_data;
  logic                 w_sat_ovfl;
  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic                 r_out_ovfl;

  assign w_stall     = r_out_valid & ~out_ready;
  assign in_ready    = ~w_stall;
  assign w_acc       = in_valid & in_ready;
  assign mac_rstn    = ~rst;
  assign mac_en_a    = ~w_stall;
  assign mac_en_b    = ~w_stall;
  assign mac_en_p    = ~w_stall;
  assign mac_mcand_a = in_a;
  assign mac_mcand_b = in_b;

  // The addend must wait one stage when the multiplicands are registered inside the MAC.
  if (BYPASS_REG_A == 0) begin : g_c_reg
    logic [P_WIDTH-1:0] r_c;
    always_ff @(posedge clk) begin
      if (rst)           r_c <= '0;
      else if (!w_stall) r_c <= in_c;
    end
    assign mac_carryin = r_c;
  end else begin : g_c_direct
    assign mac_carryin = in_c;
  end

  if (L_MAC == 0) begin : g_vpipe_none
    assign w_tail = w_acc;
  end else begin : g_vpipe
    logic [L_MAC-1:0] r_vpipe;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vpipe <= '0;
      end else if (!w_stall) begin
        r_vpipe[0] <= w_acc;
        for (int i = 1; i < L_MAC; i++) r_vpipe[i] <= r_vpipe[i-1];
      end
    end
    assign w_tail = r_vpipe[L_MAC-1];
  end

  // Convergent rounding: round half to even.
  assign w_pext = {{(RW-P_WIDTH){mac_pout[P_WIDTH-1]}}, mac_pout};
  assign w_q    = w_pext >>> SHIFT;
  assign w_frac = mac_pout[SHIFT-1:0];
  assign w_inc  = (w_frac > HALF) | ((w_frac == HALF) & w_q[0]);
  assign w_r    = w_q + {{(RW-1){1'b0}}, w_inc};

  always_comb begin
    w_sat_data = w_r[OUT_WIDTH-1:0];
    w_sat_ovfl = 1'b0;
    if (w_r > MAXV) begin
      w_sat_data = MAXV[OUT_WIDTH-1:0];
      w_sat_ovfl = 1'b1;
    end else if (w_r < MINV) begin
      w_sat_data = MINV[OUT_WIDTH-1:0];
      w_sat_ovfl = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovfl  <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= w_tail;
      if (w_tail) begin
        r_out_data <= w_sat_data;
        r_out_ovfl <= w_sat_ovfl;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovfl  = r_out_ovfl;

`ifdef FFT_INPL_MAC_CTRL_STATS_EN
  logic [15:0] r_ovfl_cnt;
  always_ff @(posedge clk) begin
    if (rst || ovfl_clr) begin
      r_ovfl_cnt <= '0;
    end else if (r_out_valid && out_ready && r_out_ovfl && (r_ovfl_cnt != 16'hFFFF)) begin
      r_ovfl_cnt <= r_ovfl_cnt + 16'd1;
    end
  end
  assign ovfl_cnt = r_ovfl_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = ovfl_clr;
  assign ovfl_cnt     = '0;
`endif

endmodule

// File: tb/tb_fft_inpl_mac_ctrl.sv
// Bench for fft_inpl_mac_ctrl: default-latency instance plus a fully bypassed instance,
// each driving a behavioural model of the hard MAC.
module tb_fft_inpl_mac_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, ovfl_clr;
  logic [17:0] in_a, in_b;
  logic [40:0] in_c;

  logic        in_ready, mac_rstn, mac_en_a, mac_en_b, mac_en_p, out_valid, out_ovfl;
  logic [17:0] mac_mcand_a, mac_mcand_b, out_data;
  logic [40:0] mac_carryin, mac_pout;
  logic [15:0] ovfl_cnt;

  logic        in_ready_1, mac_rstn_1, mac_en_a_1, mac_en_b_1, mac_en_p_1, out_valid_1, out_ovfl_1;
  logic [17:0] mac_mcand_a_1, mac_mcand_b_1, out_data_1;
  logic [40:0] mac_carryin_1, mac_pout_1;
  logic [15:0] ovfl_cnt_1;

  fft_inpl_mac_ctrl u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .mac_rstn(mac_rstn),
    .mac_en_a(mac_en_a), .mac_en_b(mac_en_b), .mac_en_p(mac_en_p),
    .mac_mcand_a(mac_mcand_a), .mac_mcand_b(mac_mcand_b), .mac_carryin(mac_carryin),
    .mac_pout(mac_pout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovfl(out_ovfl), .ovfl_clr(ovfl_clr), .ovfl_cnt(ovfl_cnt)
  );

  fft_inpl_mac_ctrl #(.BYPASS_REG_A(1), .BYPASS_REG_P(1)) u_dut_byp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .mac_rstn(mac_rstn_1),
    .mac_en_a(mac_en_a_1), .mac_en_b(mac_en_b_1), .mac_en_p(mac_en_p_1),
    .mac_mcand_a(mac_mcand_a_1), .mac_mcand_b(mac_mcand_b_1), .mac_carryin(mac_carryin_1),
    .mac_pout(mac_pout_1), .out_valid(out_valid_1), .out_ready(out_ready),
    .out_data(out_data_1), .out_ovfl(out_ovfl_1), .ovfl_clr(ovfl_clr), .ovfl_cnt(ovfl_cnt_1)
  );

  function automatic logic [40:0] mul(input logic signed [17:0] a, input logic signed [17:0] b);
    logic signed [40:0] ea, eb;
    ea = a;
    eb = b;
    return ea * eb;
  endfunction

  // MAC with A/B and P registers, synchronous active-low reset.
  logic [17:0] m_a, m_b;
  logic [40:0] m_p;
  always @(posedge clk) begin
    if (!mac_rstn) begin
      m_a <= '0; m_b <= '0; m_p <= '0;
    end else begin
      if (mac_en_a) m_a <= mac_mcand_a;
      if (mac_en_b) m_b <= mac_mcand_b;
      if (mac_en_p) m_p <= mul(m_a, m_b) + mac_carryin;
    end
  end
  assign mac_pout   = m_p;
  assign mac_pout_1 = mul(mac_mcand_a_1, mac_mcand_b_1) + mac_carryin_1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic [40:0] c;
    int          d;
    bit          o;
  } vec_t;

  // One isolated beat: bypassed instance answers after 1 cycle, default after 3.
  task automatic run_beat(input vec_t v, input string nm);
    tick();
    in_valid = 1'b1; in_a = v.a; in_b = v.b; in_c = v.c;
    tick();
    in_valid = 1'b0; in_c = '0;
    chk({nm, "_byp_valid"}, out_valid_1, 1);
    chk({nm, "_byp_data"}, $signed(out_data_1), v.d);
    chk({nm, "_byp_ovfl"}, out_ovfl_1, v.o);
    chk({nm, "_lat1"}, out_valid, 0);
    tick();
    chk({nm, "_lat2"}, out_valid, 0);
    tick();
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_data"}, $signed(out_data), v.d);
    chk({nm, "_ovfl"}, out_ovfl, v.o);
  endtask

  vec_t vecs[9];
  vec_t v6;
  int   got[$];
  int   k;

  initial begin
    #500000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

  initial begin
    // Products are Q17; 18'h20000 is -2^17 so -k * -2^17 == k * 2^17.
    vecs[0] = '{18'd1000, 18'd1000, 41'd0, 8, 1'b0};
    vecs[1] = '{18'd256, 18'd256, 41'd0, 0, 1'b0};
    vecs[2] = '{18'd256, 18'd768, 41'd0, 2, 1'b0};
    vecs[3] = '{-18'sd256, 18'd256, 41'd0, 0, 1'b0};
    vecs[4] = '{18'h20000, 18'h20000, 41'd0, 131071, 1'b1};
    vecs[5] = '{18'd131071, 18'h20000, 41'd0, -131071, 1'b0};
    vecs[6] = '{18'd0, 18'd0, -41'sd34359738368, -131072, 1'b1};
    vecs[7] = '{18'd0, 18'd0, 41'd720896, 6, 1'b0};
    vecs[8] = '{18'd0, 18'd0, 41'd589824, 4, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovfl_clr = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovfl", out_ovfl, 0);
    chk("rst_mac_rstn", mac_rstn, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_mac_rstn", mac_rstn, 1);
    chk("post_rst_valid", out_valid, 0);
    chk("cnt_zero", ovfl_cnt, 0);

    for (int i = 0; i < 9; i++) run_beat(vecs[i], $sformatf("vec%0d", i));
    tick();
`ifdef FFT_INPL_MAC_CTRL_STATS_EN
    chk("ovfl_cnt", ovfl_cnt, 2);
`else
    chk("ovfl_cnt", ovfl_cnt, 0);
`endif

    // Carry must meet its own product on back-to-back beats.
    in_valid = 1'b1; in_a = 18'd1; in_b = 18'd1; in_c = 41'd393216;
    tick();
    in_a = 18'd2; in_b = 18'd2; in_c = '0;
    tick();
    in_valid = 1'b0;
    chk("carry_lat", out_valid, 0);
    tick();
    chk("carry_v0", out_valid, 1);
    chk("carry_d0", $signed(out_data), 3);
    tick();
    chk("carry_v1", out_valid, 1);
    chk("carry_d1", $signed(out_data), 0);
    tick();
    chk("carry_drain", out_valid, 0);

    // Backpressure: out_ready low on cycles 4..7 of an 8-beat stream.
    k = 1;
    for (int t = 0; t < 30; t++) begin
      out_ready = !(t >= 4 && t <= 7);
      in_valid  = (k <= 8);
      in_a      = 18'(-k);
      in_b      = 18'h20000;
      in_c      = '0;
      #1;
      if (t >= 4 && t <= 7) begin
        chk($sformatf("bp_in_ready_t%0d", t), in_ready, 0);
        chk($sformatf("bp_en_a_t%0d", t), mac_en_a, 0);
        chk($sformatf("bp_en_b_t%0d", t), mac_en_b, 0);
        chk($sformatf("bp_en_p_t%0d", t), mac_en_p, 0);
        chk($sformatf("bp_hold_valid_t%0d", t), out_valid, 1);
        chk($sformatf("bp_hold_data_t%0d", t), $signed(out_data), 2);
      end
      if (out_valid && out_ready) got.push_back(int'($signed(out_data)));
      if (in_valid && in_ready) k++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", got.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < got.size()) chk($sformatf("bp_order%0d", i), got[i], i + 1);

    // Reset with two beats in flight: neither may emerge.
    tick();
    in_valid = 1'b1; in_a = 18'(-5); in_b = 18'h20000;
    tick();
    in_a = 18'(-6);
    tick();
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("mid_rst_mac_rstn", mac_rstn, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mid_rst_quiet%0d", i), out_valid, 0);
      tick();
    end
    chk("mid_rst_in_ready", in_ready, 1);
    v6 = '{18'(-3), 18'h20000, 41'd0, 3, 1'b0};
    run_beat(v6, "after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
